// File: rtl/top_level.sv
// "Program 3" pattern-count engine: counts a 5-bit pattern in a 32-byte message held in myDataMem.
// Optional build macro TOPLEVEL_CYCLE_CNT_EN adds a run-length cycle count written to mem[RES_ADDR+3].

module data_mem #(
    parameter int DEPTH = 256
) (
    input  logic       clk,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);
    logic [7:0] memory [0:DEPTH-1];

    assign rd_data = memory[rd_addr];

    // single synchronous write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            memory[wr_addr] <= wr_data;
        end
    end
endmodule

module top_level #(
    parameter int MEM_DEPTH = 256,
    parameter int NBYTES    = 32,
    parameter int PAT_ADDR  = 32,
    parameter int RES_ADDR  = 33
) (
    input  logic clk,
    input  logic reset,
    output logic done
);
    localparam logic [7:0] PAT_A    = 8'(PAT_ADDR);
    localparam logic [7:0] RES_A    = 8'(RES_ADDR);
    localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);

    typedef enum logic [2:0] {
        PAT  = 3'd0,
        SCAN = 3'd1,
        WR0  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        WR3  = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t      state_r;
    logic [4:0]  pat_r;
    logic [7:0]  idx_r;
    logic [7:0]  prev_r;
    logic [7:0]  ctb_r;
    logic [7:0]  cto_r;
    logic [7:0]  cts_r;
    logic        done_r;
`ifdef TOPLEVEL_CYCLE_CNT_EN
    logic [7:0]  cyc_r;
`endif

    logic [7:0]  rd_addr_s;
    logic [7:0]  rd_data_s;
    logic        wr_en_s;
    logic [7:0]  wr_addr_s;
    logic [7:0]  wr_data_s;
    logic [2:0]  m_in_s;
    logic [2:0]  m_x_s;
    logic [3:0]  m_sum_s;

    // windows lying entirely inside byte b
    function automatic logic [2:0] count_in(input logic [7:0] b, input logic [4:0] p);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (b[k +: 5] == p) n = n + 3'd1;
        end
        return n;
    endfunction

    // windows straddling previous byte a and current byte b
    function automatic logic [2:0] count_cross(input logic [7:0] a, input logic [7:0] b,
                                               input logic [4:0] p);
        logic [7:0] w;
        logic [2:0] n;
        w = {a[3:0], b[7:4]};
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (w[k +: 5] == p) n = n + 3'd1;
        end
        return n;
    endfunction

    data_mem #(.DEPTH(MEM_DEPTH)) myDataMem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // read address and per-byte match counts
    always_comb begin
        rd_addr_s = idx_r;
        if (state_r == PAT) begin
            rd_addr_s = PAT_A;
        end else begin
            rd_addr_s = idx_r;
        end
        m_in_s = count_in(rd_data_s, pat_r);
        m_x_s  = 3'd0;
        if (idx_r != 8'd0) begin
            m_x_s = count_cross(prev_r, rd_data_s, pat_r);
        end else begin
            m_x_s = 3'd0;
        end
        m_sum_s = {1'b0, m_in_s} + {1'b0, m_x_s};
    end

    // result write-back port, driven straight from the state register
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = 8'd0;
        wr_data_s = 8'd0;
        case (state_r)
            WR0: begin wr_en_s = 1'b1; wr_addr_s = RES_A;         wr_data_s = ctb_r; end
            WR1: begin wr_en_s = 1'b1; wr_addr_s = RES_A + 8'd1;  wr_data_s = cto_r; end
            WR2: begin wr_en_s = 1'b1; wr_addr_s = RES_A + 8'd2;  wr_data_s = cts_r; end
`ifdef TOPLEVEL_CYCLE_CNT_EN
            WR3: begin wr_en_s = 1'b1; wr_addr_s = RES_A + 8'd3;  wr_data_s = cyc_r; end
`endif
            default: begin wr_en_s = 1'b0; wr_addr_s = 8'd0; wr_data_s = 8'd0; end
        endcase
    end

    // control FSM and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= PAT;
            pat_r   <= 5'd0;
            idx_r   <= 8'd0;
            prev_r  <= 8'd0;
            ctb_r   <= 8'd0;
            cto_r   <= 8'd0;
            cts_r   <= 8'd0;
            done_r  <= 1'b0;
`ifdef TOPLEVEL_CYCLE_CNT_EN
            cyc_r   <= 8'd0;
`endif
        end else begin
`ifdef TOPLEVEL_CYCLE_CNT_EN
            if (!done_r) cyc_r <= cyc_r + 8'd1;
`endif
            case (state_r)
                PAT: begin
                    pat_r   <= rd_data_s[7:3];
                    state_r <= SCAN;
                end
                SCAN: begin
                    ctb_r  <= ctb_r + {5'd0, m_in_s};
                    cto_r  <= cto_r + {7'd0, (m_in_s != 3'd0)};
                    cts_r  <= cts_r + {4'd0, m_sum_s};
                    prev_r <= rd_data_s;
                    if (idx_r == LAST_IDX) begin
                        state_r <= WR0;
                    end else begin
                        idx_r <= idx_r + 8'd1;
                    end
                end
                WR0: state_r <= WR1;
                WR1: state_r <= WR2;
`ifdef TOPLEVEL_CYCLE_CNT_EN
                WR2: state_r <= WR3;
                WR3: begin
                    state_r <= DONE;
                    done_r  <= 1'b1;
                end
`else
                WR2: begin
                    state_r <= DONE;
                    done_r  <= 1'b1;
                end
`endif
                DONE: state_r <= DONE;
                default: state_r <= PAT;
            endcase
        end
    end

    assign done = done_r;
endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for top_level: stimulus pushes expected results, a monitor checks them when done rises.

module tb_top_level;
    logic clk;
    logic reset;
    logic done;

    top_level dut (.clk(clk), .reset(reset), .done(done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] ctb;
        logic [7:0] cto;
        logic [7:0] cts;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] msg [0:31];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         resp_cnt = 0;
    bit         done_seen = 1'b0;

`ifdef TOPLEVEL_CYCLE_CNT_EN
    localparam int LAT = 37;
`else
    localparam int LAT = 36;
`endif

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // monitor: sample 1 time unit after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset) begin
            cyc = 0;
            done_seen = 1'b0;
            check("reset_done", int'(done), 0);
        end else if (!done_seen) begin
            cyc++;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_ctb"}, int'(dut.myDataMem.memory[33]), int'(e.ctb));
                    check({e.name, "_cto"}, int'(dut.myDataMem.memory[34]), int'(e.cto));
                    check({e.name, "_cts"}, int'(dut.myDataMem.memory[35]), int'(e.cts));
                    check({e.name, "_latency"}, cyc, LAT);
                end
                resp_cnt++;
            end else if (cyc > 45) begin
                done_seen = 1'b1;
                check("done_timeout", cyc, LAT);
                if (exp_q.size() != 0) e = exp_q.pop_front();
                resp_cnt++;
            end
        end
    end

    task automatic load(input logic [7:0] patb);
        for (int i = 0; i < 32; i++) dut.myDataMem.memory[i] = msg[i];
        dut.myDataMem.memory[32] = patb;
    endtask

    // assert reset across one edge, load data, queue expectation, release, wait for response
    task automatic run(input string nm, input logic [7:0] patb,
                       input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        exp_t e;
        int   start;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load(patb);
        e.name = nm; e.ctb = e0; e.cto = e1; e.cts = e2;
        exp_q.push_back(e);
        start = resp_cnt;
        reset = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (resp_cnt != start) break;
        end
        if (resp_cnt == start) check({nm, "_no_response"}, 0, 1);
    endtask

    // reference: explicit 256-bit string scan
    task automatic model(input logic [7:0] patb, output logic [7:0] a, output logic [7:0] b,
                         output logic [7:0] c);
        logic [255:0] s;
        logic [4:0]   p;
        int           na, nb, nc;
        bit           hit;
        p = patb[7:3];
        for (int i = 0; i < 32; i++) s[255 - 8*i -: 8] = msg[i];
        na = 0; nb = 0; nc = 0;
        for (int j = 0; j < 252; j++) begin
            if (s[j +: 5] == p) begin
                nc++;
                if ((j % 8) <= 3) na++;
            end
        end
        for (int i = 0; i < 32; i++) begin
            hit = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (s[8*(31-i) + k +: 5] == p) hit = 1'b1;
            end
            if (hit) nb++;
        end
        a = 8'(na); b = 8'(nb); c = 8'(nc);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 32; i++) msg[i] = v;
    endtask

    initial begin
        logic [7:0] e0, e1, e2, pb;
        reset = 1'b1;
        dut.myDataMem.memory[36] = 8'h5A;

        fill(8'h55);                   run("alt55",  8'hA8, 8'd64,  8'd32, 8'd126);
        fill(8'h00);                   run("zeros",  8'h00, 8'd128, 8'd32, 8'd252);
        fill(8'h00);                   run("nomatch", 8'hA8, 8'd0,  8'd0,  8'd0);
        fill(8'h00); msg[0] = 8'hF8;   run("single", 8'hF8, 8'd1,   8'd1,  8'd1);
        fill(8'h00); msg[0] = 8'h03; msg[1] = 8'hE0;
                                       run("cross",  8'hF8, 8'd0,   8'd0,  8'd1);

        // abort a run mid-scan, then restart on new data
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fill(8'hFF);
        load(8'hF8);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        fill(8'h55);                   run("abort_new", 8'hA8, 8'd64, 8'd32, 8'd126);
`ifdef TOPLEVEL_CYCLE_CNT_EN
        check("mem36_cycles", int'(dut.myDataMem.memory[36]), 36);
`else
        check("mem36_untouched", int'(dut.myDataMem.memory[36]), 8'h5A);
`endif

        for (int r = 0; r < 20; r++) begin
            pb = 8'($urandom);
            for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
            if (r % 2 == 0) begin
                for (int i = 0; i < 32; i += 3) msg[i] = pb;
            end
            model(pb, e0, e1, e2);
            run($sformatf("rand%0d", r), pb, e0, e1, e2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
